knn_topk_voter: RTL and testbench
=================================

KNN_TOPK_VOTER -- requirements
Module: knn_topk_voter

Interface
REQ-001 Parameter K, default 5, number of nearest neighbours retained (1..16).
REQ-002 Parameter DIST_W, default 32, distance width in bits (matches ALU result width).
REQ-003 Parameter LABEL_W, default 3, class label width; NUM_CLASSES = 2**LABEL_W.
REQ-004 clock  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  single-cycle pulse; clears the neighbour table and begins a query.
REQ-007 in_valid  input  1  distance/label pair offered.
REQ-008 in_ready  output  1  pair accepted when in_valid && in_ready.
REQ-009 in_dist  input  DIST_W  unsigned distance from the ALU stage.
REQ-010 in_label  input  LABEL_W  label from label memory for the same sample.
REQ-011 in_last  input  1  qualifies the final pair of the query.
REQ-012 result_valid  output  1  classification available.
REQ-013 result_ready  input  1  consumer accepts the result.
REQ-014 result_label  output  LABEL_W  predicted class.
REQ-015 busy  output  1  high in every state except IDLE.

Function
REQ-016 FSM states: IDLE, COLLECT, VOTE, ARGMAX, DONE.
REQ-017 IDLE -> COLLECT on start; the same edge clears all K valid bits and all vote counters.
REQ-018 in_ready SHALL be 1 only in COLLECT.
REQ-019 Table is kept sorted ascending by distance; entry 0 is nearest.
REQ-020 Accepted pair is inserted in the same cycle at the first position whose entry is invalid or has a strictly greater distance; lower entries shift down by one; entry K-1 is discarded.
REQ-021 Pair is dropped if all K entries are valid and in_dist >= entry K-1 distance; ties therefore keep the earlier arrival.
REQ-022 Accepted pair with in_last=1 is inserted, then the next state is VOTE.
REQ-023 VOTE lasts exactly K cycles; cycle i increments counter[label_i] if entry i is valid; counters are clog2(K+1) bits wide and cannot overflow.
REQ-024 ARGMAX lasts exactly NUM_CLASSES cycles, scanning classes 0..NUM_CLASSES-1; a class replaces the current best only on a strictly greater count, so ties resolve to the lowest label.
REQ-025 DONE: result_valid=1 and result_label is held stable until result_ready=1; that edge returns the FSM to IDLE.
REQ-026 Latency: in_last accepted at edge t -> result_valid high from edge t+K+NUM_CLASSES+1.
REQ-027 start is ignored outside IDLE; a start coincident with result handshake in DONE is ignored.
REQ-028 A query with fewer than K samples votes only over valid entries.

Reset
REQ-029 Reset assertion forces IDLE, clears valid bits and counters, and drives in_ready=0, result_valid=0, result_label=0, busy=0 asynchronously.
REQ-030 Reset mid-query abandons the query; no result is produced.

Configuration
REQ-031 Macro KNN_VOTE_EN: when defined, behaviour is as in REQ-023..REQ-026.
REQ-032 When KNN_VOTE_EN is undefined, VOTE, ARGMAX and the counters are omitted; COLLECT -> DONE directly; result_label = entry 0 label; latency is t+1.

Verification
REQ-033 K=3, dists 40,10,30,20 labels 1,2,3,2, last on the 4th -> table {10/2, 20/2, 30/3}; result_label=2 at edge t+12.
REQ-034 K=3, dists 5,5,5,5 labels 1,2,3,4 -> table keeps labels 1,2,3; three-way tie resolves to result_label=1.
REQ-035 K=3, single pair dist 7 label 6 with last -> one valid entry; result_label=6.
REQ-036 Hold result_ready=0 for 10 cycles in DONE -> result_valid and result_label stable; in_ready=0; a start pulse is ignored.
REQ-037 Assert reset two cycles into VOTE -> outputs zero immediately; after release, busy=0, no result_valid; a new query classifies correctly.
REQ-038 Build without KNN_VOTE_EN, same stimulus as REQ-033 -> result_label=2 (label of dist 10) at edge t+1.

Source files
------------

// File: rtl/knn_topk_voter.sv
// k-NN top-K neighbour table with majority vote over the K nearest labels.
// Optional macro KNN_VOTE_EN enables the VOTE/ARGMAX stages; without it the result is the nearest label.
module knn_topk_voter #(
    parameter int K       = 5,
    parameter int DIST_W  = 32,
    parameter int LABEL_W = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DIST_W-1:0]  in_dist,
    input  logic [LABEL_W-1:0] in_label,
    input  logic               in_last,
    output logic               result_valid,
    input  logic               result_ready,
    output logic [LABEL_W-1:0] result_label,
    output logic               busy
);
    localparam int NUM_CLASSES = 2 ** LABEL_W;

    typedef enum logic [2:0] {IDLE, COLLECT, VOTE, ARGMAX, DONE} state_e;

    state_e               state_q, state_d;
    logic [K-1:0]         valid_q, valid_d;
    logic [DIST_W-1:0]    dist_q  [K];
    logic [DIST_W-1:0]    dist_d  [K];
    logic [LABEL_W-1:0]   label_q [K];
    logic [LABEL_W-1:0]   label_d [K];
    logic                 result_valid_q, result_valid_d;
    logic [LABEL_W-1:0]   result_label_q, result_label_d;
    logic [LABEL_W-1:0]   best_label;

    logic [K-1:0]         gt, gt_prev;
    logic [K-1:0]         sh_valid;
    logic [DIST_W-1:0]    sh_dist  [K];
    logic [LABEL_W-1:0]   sh_label [K];
    logic                 accept;

`ifdef KNN_VOTE_EN
    localparam int CNT_W = $clog2(K + 1);
    localparam int IDX_W = $clog2((K > NUM_CLASSES) ? K : NUM_CLASSES);

    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [CNT_W-1:0]   cnt_q [NUM_CLASSES];
    logic [CNT_W-1:0]   cnt_d [NUM_CLASSES];
    logic [CNT_W-1:0]   best_cnt_q, best_cnt_d;
    logic [LABEL_W-1:0] best_lbl_q, best_lbl_d;
    logic               vote_hit;
    logic [LABEL_W-1:0] vote_lbl;
    logic [CNT_W-1:0]   scan_cnt;

    always_comb begin
        vote_hit = 1'b0;
        vote_lbl = '0;
        scan_cnt = '0;
        for (int i = 0; i < K; i++) begin
            if (idx_q == IDX_W'(i) && valid_q[i]) begin
                vote_hit = 1'b1;
                vote_lbl = label_q[i];
            end
        end
        for (int c = 0; c < NUM_CLASSES; c++) begin
            if (idx_q == IDX_W'(c)) scan_cnt = cnt_q[c];
        end
    end

    assign best_label = best_lbl_q;
`else
    assign best_label = label_q[0];
`endif

    assign accept = in_valid && in_ready;

    // Valid entries form a prefix and distances ascend, so gt is a thermometer:
    // the first set bit is the insertion slot, later set bits take the shifted entry.
    always_comb begin
        for (int i = 0; i < K; i++) begin
            gt[i]       = !valid_q[i] || (dist_q[i] > in_dist);
            sh_valid[i] = 1'b0;
            sh_dist[i]  = in_dist;
            sh_label[i] = in_label;
        end
        for (int i = 1; i < K; i++) begin
            sh_valid[i] = valid_q[i-1];
            sh_dist[i]  = dist_q[i-1];
            sh_label[i] = label_q[i-1];
        end
        gt_prev = gt << 1;
    end

    always_comb begin
        state_d        = state_q;
        valid_d        = valid_q;
        result_valid_d = result_valid_q;
        result_label_d = result_label_q;
        for (int i = 0; i < K; i++) begin
            dist_d[i]  = dist_q[i];
            label_d[i] = label_q[i];
        end
`ifdef KNN_VOTE_EN
        idx_d      = idx_q;
        best_cnt_d = best_cnt_q;
        best_lbl_d = best_lbl_q;
        for (int c = 0; c < NUM_CLASSES; c++) cnt_d[c] = cnt_q[c];
`endif
        if (accept) begin
            for (int i = 0; i < K; i++) begin
                if (gt[i]) begin
                    if (!gt_prev[i]) begin
                        valid_d[i] = 1'b1;
                        dist_d[i]  = in_dist;
                        label_d[i] = in_label;
                    end else begin
                        valid_d[i] = sh_valid[i];
                        dist_d[i]  = sh_dist[i];
                        label_d[i] = sh_label[i];
                    end
                end
            end
        end
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = COLLECT;
                    valid_d = '0;
`ifdef KNN_VOTE_EN
                    for (int c = 0; c < NUM_CLASSES; c++) cnt_d[c] = '0;
`endif
                end
            end
            COLLECT: begin
                if (accept && in_last) begin
`ifdef KNN_VOTE_EN
                    state_d = VOTE;
                    idx_d   = '0;
`else
                    state_d = DONE;
`endif
                end
            end
`ifdef KNN_VOTE_EN
            VOTE: begin
                if (vote_hit) cnt_d[vote_lbl] = cnt_q[vote_lbl] + CNT_W'(1);
                idx_d = idx_q + IDX_W'(1);
                if (idx_q == IDX_W'(K - 1)) begin
                    state_d    = ARGMAX;
                    idx_d      = '0;
                    best_cnt_d = '0;
                    best_lbl_d = '0;
                end
            end
            ARGMAX: begin
                // Strictly-greater keeps the lowest label on ties.
                if (scan_cnt > best_cnt_q) begin
                    best_cnt_d = scan_cnt;
                    best_lbl_d = LABEL_W'(idx_q);
                end
                idx_d = idx_q + IDX_W'(1);
                if (idx_q == IDX_W'(NUM_CLASSES - 1)) state_d = DONE;
            end
`endif
            DONE: begin
                // First DONE cycle commits the result; it then holds until accepted.
                if (!result_valid_q) begin
                    result_valid_d = 1'b1;
                    result_label_d = best_label;
                end else if (result_ready) begin
                    result_valid_d = 1'b0;
                    state_d        = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            valid_q        <= '0;
            result_valid_q <= 1'b0;
            result_label_q <= '0;
            for (int i = 0; i < K; i++) begin
                dist_q[i]  <= '0;
                label_q[i] <= '0;
            end
        end else begin
            state_q        <= state_d;
            valid_q        <= valid_d;
            result_valid_q <= result_valid_d;
            result_label_q <= result_label_d;
            for (int i = 0; i < K; i++) begin
                dist_q[i]  <= dist_d[i];
                label_q[i] <= label_d[i];
            end
        end
    end

`ifdef KNN_VOTE_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q      <= '0;
            best_cnt_q <= '0;
            best_lbl_q <= '0;
            for (int c = 0; c < NUM_CLASSES; c++) cnt_q[c] <= '0;
        end else begin
            idx_q      <= idx_d;
            best_cnt_q <= best_cnt_d;
            best_lbl_q <= best_lbl_d;
            for (int c = 0; c < NUM_CLASSES; c++) cnt_q[c] <= cnt_d[c];
        end
    end
`endif

    assign in_ready     = (state_q == COLLECT);
    assign busy         = (state_q != IDLE);
    assign result_valid = result_valid_q;
    assign result_label = result_label_q;
endmodule

// File: tb/tb_knn_topk_voter.sv
// Scoreboard bench for knn_topk_voter (K=3, LABEL_W=3); latency follows KNN_VOTE_EN.
module tb_knn_topk_voter;
    localparam int K  = 3;
    localparam int DW = 32;
    localparam int LW = 3;
    localparam int NC = 8;
`ifdef KNN_VOTE_EN
    localparam int LAT = K + NC + 1;
`else
    localparam int LAT = 1;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_dist = '0;
    logic [LW-1:0] in_label = '0;
    logic          in_last = 1'b0;
    logic          result_valid;
    logic          result_ready = 1'b1;
    logic [LW-1:0] result_label;
    logic          busy;

    knn_topk_voter #(.K(K), .DIST_W(DW), .LABEL_W(LW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .in_valid(in_valid), .in_ready(in_ready), .in_dist(in_dist),
        .in_label(in_label), .in_last(in_last),
        .result_valid(result_valid), .result_ready(result_ready),
        .result_label(result_label), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int passed = 0;
    int total  = 0;

    typedef struct {
        logic [LW-1:0] lbl;
        int            due;
    } exp_t;
    exp_t sb[$];

    task automatic chk(input string name, input int got, input int exp);
        total++;
        if (got == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, got, exp);
    endtask

    // Monitor: pops on each new result, checks label, arrival edge and hold stability.
    initial begin
        logic          prev_rv;
        logic [LW-1:0] held;
        exp_t          e;
        prev_rv = 1'b0;
        held    = '0;
        forever begin
            @(negedge clk);
            if (rst_n && result_valid && !prev_rv) begin
                if (sb.size() == 0) begin
                    total++;
                    $display("FAIL unexpected_result: got label %0d expected no result", result_label);
                end else begin
                    e = sb.pop_front();
                    chk("result_label", int'(result_label), int'(e.lbl));
                    chk("latency_edge", cyc, e.due);
                end
                held = result_label;
            end else if (rst_n && result_valid && prev_rv) begin
                chk("hold_label", int'(result_label), int'(held));
            end
            prev_rv = rst_n && result_valid;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send(input int d, input int l, input bit last, input bit push, input int exp_lbl);
        bit   rdy;
        int   n;
        exp_t e;
        n        = 0;
        in_valid = 1'b1;
        in_dist  = DW'(d);
        in_label = LW'(l);
        in_last  = last;
        do begin
            rdy = in_ready;
            tick();
            n++;
        end while (!rdy && n < 50);
        in_valid = 1'b0;
        in_last  = 1'b0;
        if (!rdy) begin
            total++;
            $display("FAIL send_timeout: got in_ready=0 expected 1");
        end else if (last && push) begin
            e.lbl = LW'(exp_lbl);
            e.due = cyc + LAT;
            sb.push_back(e);
        end
    endtask

    task automatic query(input int d[8], input int l[8], input int n, input int exp_lbl);
        pulse_start();
        for (int i = 0; i < n; i++) send(d[i], l[i], (i == n - 1), 1'b1, exp_lbl);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            tick();
            n++;
        end
        if (sb.size() != 0) begin
            total++;
            $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
            sb.delete();
        end
        tick();
        tick();
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_in_ready"}, int'(in_ready), 0);
        chk({tag, "_result_valid"}, int'(result_valid), 0);
    endtask

    initial begin
        int seen;
        int n;
        // Reset state
        repeat (3) tick();
        chk_idle_outputs("reset");
        chk("reset_label", int'(result_label), 0);
        rst_n = 1'b1;
        tick();
        chk_idle_outputs("post_reset");

        // Out-of-order arrivals sorted into {10/2,20/2,30/3}
        query('{40, 10, 30, 20, 0, 0, 0, 0}, '{1, 2, 3, 2, 0, 0, 0, 0}, 4, 2);
        drain();
        // Equal distances: earliest three kept, tie resolves to 1 (also nearest)
        query('{5, 5, 5, 5, 0, 0, 0, 0}, '{1, 2, 3, 4, 0, 0, 0, 0}, 4, 1);
        drain();
        // Single sample, partial table
        query('{7, 0, 0, 0, 0, 0, 0, 0}, '{6, 0, 0, 0, 0, 0, 0, 0}, 1, 6);
        drain();
        // Majority differs from nearest
`ifdef KNN_VOTE_EN
        query('{10, 20, 30, 0, 0, 0, 0, 0}, '{5, 3, 3, 0, 0, 0, 0, 0}, 3, 3);
`else
        query('{10, 20, 30, 0, 0, 0, 0, 0}, '{5, 3, 3, 0, 0, 0, 0, 0}, 3, 5);
`endif
        drain();
        // Descending arrivals evict the far entries
        query('{50, 40, 30, 20, 10, 0, 0, 0}, '{7, 7, 7, 1, 1, 0, 0, 0}, 5, 1);
        drain();

        // Result held under back-pressure; start inside DONE is ignored
        result_ready = 1'b0;
        query('{40, 10, 30, 20, 0, 0, 0, 0}, '{1, 2, 3, 2, 0, 0, 0, 0}, 4, 2);
        n = 0;
        while (!result_valid && n < 100) begin
            tick();
            n++;
        end
        chk("bp_valid_seen", int'(result_valid), 1);
        for (int i = 0; i < 10; i++) begin
            if (i == 5) pulse_start();
            else tick();
            chk("bp_valid", int'(result_valid), 1);
            chk("bp_in_ready", int'(in_ready), 0);
            chk("bp_busy", int'(busy), 1);
        end
        start        = 1'b1;
        result_ready = 1'b1;
        tick();
        start = 1'b0;
        chk_idle_outputs("after_handshake");
        drain();

        // Reset mid-query abandons it
        pulse_start();
        send(40, 1, 1'b0, 1'b0, 0);
        send(10, 2, 1'b0, 1'b0, 0);
`ifdef KNN_VOTE_EN
        send(30, 3, 1'b1, 1'b0, 0);
        tick();
        tick();
`endif
        rst_n = 1'b0;
        #1;
        chk_idle_outputs("async_reset");
        chk("async_reset_label", int'(result_label), 0);
        tick();
        tick();
        rst_n = 1'b1;
        seen  = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (result_valid) seen++;
        end
        chk("no_result_after_reset", seen, 0);
        chk("busy_after_reset", int'(busy), 0);

        query('{40, 10, 30, 20, 0, 0, 0, 0}, '{1, 2, 3, 2, 0, 0, 0, 0}, 4, 2);
        drain();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
